// File: rtl/rib_arbiter.sv
// Registered round-robin arbiter for the four-master system bus.
// Grants are lockable and bounded by a MAX_HOLD preemption counter; hold_flag_o stalls waiting requesters.
module rib_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic [3:0] lock_i,
    output logic [1:0] grant_o,
    output logic [3:0] grant_oh_o,
    output logic       grant_valid_o,
    output logic       hold_flag_o,
    output logic       dbg_state_o
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_grant;
    logic [1:0]      w_grant_nxt;
    logic [1:0]      r_ptr;
    logic [1:0]      w_ptr_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    logic [3:0]      w_gmask;
    logic [3:0]      w_others;
    logic            w_release;
    logic            w_valid;

    // First requester in the order p+1, p+2, p+3, p.
    function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign w_valid   = (r_state == GRANTED);
    assign w_gmask   = 4'b0001 << r_grant;
    assign w_others  = req_i & ~w_gmask;
    assign w_release = !req_i[r_grant] ||
                       ((r_cnt == CNT_MAX) && !lock_i[r_grant] && (|w_others));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|req_i) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = rr_pick(r_ptr, req_i);
                    w_ptr_nxt   = w_grant_nxt;
                    w_cnt_nxt   = '0;
                end
            end
            GRANTED: begin
                if (w_release) begin
                    // Hand over directly when anyone else waits, so there is no idle bubble.
                    if (|w_others) begin
                        w_grant_nxt = rr_pick(r_grant, w_others);
                        w_ptr_nxt   = w_grant_nxt;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign grant_o       = r_grant;
    assign grant_valid_o = w_valid;
    assign grant_oh_o    = w_valid ? w_gmask : 4'b0000;
    assign hold_flag_o   = rst ? 1'b0 : |(req_i & ~grant_oh_o);
    assign dbg_state_o   = w_valid;

endmodule
